// File: rtl/controlador_memoria4k_if.sv
// Bus bundle between the request/RAM side and controlador_memoria4k:
// valid/ready request front end, read-response pulse and single-port RAM signals.
interface controlador_memoria4k_if #(
  parameter int ANCHO_DATO = 12,
  parameter int ANCHO_DIR  = 9
);
  logic                  solicitud_valida;
  logic                  solicitud_lista;
  logic                  solicitud_escribir;
  logic [ANCHO_DIR-1:0]  solicitud_direccion;
  logic [ANCHO_DATO-1:0] solicitud_dato;
  logic                  respuesta_valida;
  logic [ANCHO_DATO-1:0] respuesta_dato;
  logic                  inicializado;
  logic                  leer_escribir_memoria;
  logic [ANCHO_DIR-1:0]  direccion_memoria;
  logic [ANCHO_DATO-1:0] dato_escribir_memoria;
  logic [ANCHO_DATO-1:0] dato_leer_memoria;

  // Requester plus RAM environment.
  modport master (
    output solicitud_valida, solicitud_escribir, solicitud_direccion, solicitud_dato,
    output dato_leer_memoria,
    input  solicitud_lista, respuesta_valida, respuesta_dato, inicializado,
    input  leer_escribir_memoria, direccion_memoria, dato_escribir_memoria
  );

  // Controller side.
  modport slave (
    input  solicitud_valida, solicitud_escribir, solicitud_direccion, solicitud_dato,
    input  dato_leer_memoria,
    output solicitud_lista, respuesta_valida, respuesta_dato, inicializado,
    output leer_escribir_memoria, direccion_memoria, dato_escribir_memoria
  );
endinterface

// File: rtl/controlador_memoria4k.sv
// Controller for a single-port 512x12 block RAM: clears it after reset, then
// serves one read or write at a time from a valid/ready request port.
module controlador_memoria4k #(
  parameter int ANCHO_DATO        = 12,
  parameter int ANCHO_DIR         = 9,
  parameter int PROFUNDIDAD       = 512,
  parameter int LATENCIA_LECTURA  = 1,
  parameter int LIMPIAR_AL_INICIO = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  controlador_memoria4k_if.slave bus,
  output logic [2:0]             estado_dbg_o
);
  localparam int CONT_W = ANCHO_DIR + 1;
  localparam int LAT_W  = 2;

  // Handshake: a request is taken at a rising edge where solicitud_valida and
  // solicitud_lista are both high; the requester holds the request until then.
  typedef enum logic [2:0] {
    LIMPIAR      = 3'd0,
    LIBRE        = 3'd1,
    ESCRIBIR     = 3'd2,
    LEER_ESPERA  = 3'd3,
    LEER_CAPTURA = 3'd4
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [CONT_W-1:0]     contador_q, contador_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  we_q, we_d;
  logic [ANCHO_DIR-1:0]  dir_q, dir_d;
  logic [ANCHO_DATO-1:0] wdata_q, wdata_d;
  logic                  rv_q, rv_d;
  logic [ANCHO_DATO-1:0] rdata_q, rdata_d;
  logic                  init_q, init_d;

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    lat_d      = lat_q;
    we_d       = we_q;
    dir_d      = dir_q;
    wdata_d    = wdata_q;
    rv_d       = 1'b0;
    rdata_d    = rdata_q;
    init_d     = init_q;
    case (estado_q)
      LIMPIAR: begin
        // The counter runs one past the last address so that the write of
        // word PROFUNDIDAD-1 is still presented for a full cycle.
        if (contador_q == CONT_W'(PROFUNDIDAD)) begin
          we_d     = 1'b0;
          init_d   = 1'b1;
          estado_d = LIBRE;
        end else begin
          we_d       = 1'b1;
          dir_d      = contador_q[ANCHO_DIR-1:0];
          wdata_d    = '0;
          contador_d = contador_q + 1'b1;
        end
      end
      LIBRE: begin
        we_d = 1'b0;
        if (bus.solicitud_valida) begin
          dir_d   = bus.solicitud_direccion;
          wdata_d = bus.solicitud_dato;
          lat_d   = '0;
          if (bus.solicitud_escribir) begin
            we_d     = 1'b1;
            estado_d = ESCRIBIR;
          end else begin
            estado_d = LEER_ESPERA;
          end
        end
      end
      ESCRIBIR: begin
        we_d     = 1'b0;
        estado_d = LIBRE;
      end
      LEER_ESPERA: begin
        if (lat_q == LAT_W'(LATENCIA_LECTURA - 1)) estado_d = LEER_CAPTURA;
        else lat_d = lat_q + 1'b1;
      end
      LEER_CAPTURA: begin
        rdata_d  = bus.dato_leer_memoria;
        rv_d     = 1'b1;
        estado_d = LIBRE;
      end
      default: estado_d = LIBRE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (LIMPIAR_AL_INICIO != 0) estado_q <= LIMPIAR;
      else estado_q <= LIBRE;
      contador_q <= '0;
      lat_q      <= '0;
      we_q       <= 1'b0;
      dir_q      <= '0;
      wdata_q    <= '0;
      rv_q       <= 1'b0;
      rdata_q    <= '0;
      init_q     <= (LIMPIAR_AL_INICIO == 0);
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      lat_q      <= lat_d;
      we_q       <= we_d;
      dir_q      <= dir_d;
      wdata_q    <= wdata_d;
      rv_q       <= rv_d;
      rdata_q    <= rdata_d;
      init_q     <= init_d;
    end
  end

  assign bus.solicitud_lista       = (estado_q == LIBRE);
  assign bus.respuesta_valida      = rv_q;
  assign bus.respuesta_dato        = rdata_q;
  assign bus.inicializado          = init_q;
  assign bus.leer_escribir_memoria = we_q;
  assign bus.direccion_memoria     = dir_q;
  assign bus.dato_escribir_memoria = wdata_q;
  assign estado_dbg_o              = estado_q;
endmodule

// File: doc/controlador_memoria4k.md
Name: controlador_memoria4k

Overview:
- Initiator/controller that drives the single-port 512x12 block-RAM wrapper (clock, reset, write-enable, 9-bit address, 12-bit write data, 12-bit read data).
- Clears the whole RAM after reset, then serves one request at a time from a valid/ready front end.
- Returns read data through a one-cycle response pulse.
- Sits between the datapath/control unit and the memory wrapper.

Parameters:
- ANCHO_DATO, 12, data width.
- ANCHO_DIR, 9, address width.
- PROFUNDIDAD, 512, number of words; must equal 2**ANCHO_DIR.
- LATENCIA_LECTURA, 1, cycles from the RAM address-sampling edge to valid read data; 1 to 3.
- LIMPIAR_AL_INICIO, 1, 1 = write zero to every word after reset; 0 = skip the clear.

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset: sampled on the clock rising edge, asserted when 0.
- solicitud_valida  in  1  request present.
- solicitud_lista  out  1  controller can accept a request this cycle.
- solicitud_escribir  in  1  1 = write, 0 = read.
- solicitud_direccion  in  ANCHO_DIR  request address.
- solicitud_dato  in  ANCHO_DATO  write data.
- respuesta_valida  out  1  one-cycle pulse: respuesta_dato carries read data.
- respuesta_dato  out  ANCHO_DATO  last read data; held between reads.
- inicializado  out  1  1 once the clear has finished (or immediately if LIMPIAR_AL_INICIO = 0).
- leer_escribir_memoria  out  1  RAM write enable.
- direccion_memoria  out  ANCHO_DIR  RAM address.
- dato_escribir_memoria  out  ANCHO_DATO  RAM write data.
- dato_leer_memoria  in  ANCHO_DATO  RAM read data.

Behaviour:
- All RAM-side outputs, respuesta_* and inicializado are registered.
- solicitud_lista is a combinational decode of estado == LIBRE.
- Reset (reset = 0 at a rising edge):
  - estado goes to LIMPIAR, or to LIBRE if LIMPIAR_AL_INICIO = 0.
  - contador = 0.
  - leer_escribir_memoria = 0, direccion_memoria = 0, dato_escribir_memoria = 0.
  - respuesta_valida = 0, respuesta_dato = 0.
  - inicializado = 0, or 1 if LIMPIAR_AL_INICIO = 0.
- Reset mid-operation: any in-flight read or clear is aborted with no response pulse, and the clear restarts from address 0.
- States: LIMPIAR, LIBRE, ESCRIBIR, LEER_ESPERA, LEER_CAPTURA.
- LIMPIAR:
  - Each cycle drives leer_escribir_memoria = 1, direccion_memoria = contador, dato_escribir_memoria = 0; contador increments.
  - After the word at PROFUNDIDAD-1 is written, leer_escribir_memoria = 0, inicializado = 1 and estado goes to LIBRE.
  - Duration: exactly PROFUNDIDAD write cycles; inicializado rises PROFUNDIDAD+1 edges after reset deasserts.
  - solicitud_lista = 0 throughout; requests are not accepted and the requester holds them.
- LIBRE:
  - solicitud_lista = 1 and leer_escribir_memoria = 0.
  - Handshake: a request is accepted at the edge where solicitud_valida && solicitud_lista; direccion_memoria and dato_escribir_memoria are loaded at that edge.
  - Accepted write: leer_escribir_memoria goes to 1, estado goes to ESCRIBIR.
  - Accepted read: leer_escribir_memoria stays 0, estado goes to LEER_ESPERA.
- ESCRIBIR:
  - The RAM samples the write on this cycle's edge; leer_escribir_memoria then returns to 0 and estado goes to LIBRE.
  - Write throughput: one every 2 cycles.
- LEER_ESPERA:
  - The RAM samples the address; estado waits LATENCIA_LECTURA cycles on a latency counter, then goes to LEER_CAPTURA.
- LEER_CAPTURA:
  - respuesta_dato <= dato_leer_memoria and respuesta_valida = 1 for exactly 1 cycle; estado goes to LIBRE.
- Read timing: accepted at edge N, respuesta_valida is high in the cycle after edge N+1+LATENCIA_LECTURA, i.e. 2+LATENCIA_LECTURA cycles per read.
- Read-after-write to the same address returns the new data, since the write has completed before the next acceptance.
- Addresses: full range 0..PROFUNDIDAD-1; no wrap or out-of-range case exists.
- While solicitud_lista = 0, request inputs are don't-care.
- respuesta_valida never asserts outside LEER_CAPTURA.

Test Plan:
- Reset 3 cycles, release, LIMPIAR_AL_INICIO = 1 -> 512 consecutive write-enable cycles at addresses 0..511 with data 0; inicializado rises on the 513th edge; solicitud_lista stays 0 until then.
- After init: write addr 0x1A5 data 0xABC, then read 0x1A5 -> one respuesta_valida pulse with respuesta_dato = 0xABC, 3 cycles after read acceptance (LATENCIA_LECTURA = 1); respuesta_dato holds 0xABC afterwards.
- Read addr 0x000 and 0x1FF before any write -> 0x000 each; boundary addresses reached correctly.
- solicitud_valida held high with alternating writes 0x001..0x004 to addrs 1..4 -> acceptances every 2 cycles; the RAM model matches afterwards; no respuesta_valida pulses during writes.
- Reset asserted 1 cycle into LEER_ESPERA and at clear address 200 -> no response pulse; clear restarts at address 0; inicializado = 0 until the full 512-cycle clear finishes.
- LATENCIA_LECTURA = 3 and LIMPIAR_AL_INICIO = 0 -> inicializado = 1 and solicitud_lista = 1 the cycle after reset; a read of a written word returns correct data 5 cycles after acceptance.
